// File: rtl/mem_pkg.sv
// Shared types and constants for the byte-enable memory controller.
// Build option: MEM_CLEAR_EN (see mem_be_ctrl.sv).
package mem_pkg;

    localparam int unsigned WORD_W = 32;

    // Byte-enable patterns that are legal when the address alignment matches.
    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_BYTE1   = 4'b0010;
    localparam logic [3:0] BE_BYTE2   = 4'b0100;
    localparam logic [3:0] BE_BYTE3   = 4'b1000;

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // True when the byte-enable pattern agrees with the low address bits.
    function automatic logic be_legal(input logic [3:0] be, input logic [1:0] a_lo);
        logic ok;
        ok = 1'b0;
        case (be)
            BE_WORD:    ok = (a_lo == 2'b00);
            BE_HALF_LO: ok = (a_lo == 2'b00);
            BE_HALF_HI: ok = (a_lo == 2'b10);
            BE_BYTE0:   ok = (a_lo == 2'b00);
            BE_BYTE1:   ok = (a_lo == 2'b01);
            BE_BYTE2:   ok = (a_lo == 2'b10);
            BE_BYTE3:   ok = (a_lo == 2'b11);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_be_chk.sv
// Combinational access check: byte-enable/alignment legality and address range.
module mem_be_chk
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic [31:0] i_a,
    input  logic [3:0]  i_be,
    output logic        o_fault
);

    logic [31:0] w_hi;
    logic        w_oor;

    assign w_hi    = i_a >> (ADDR_W + 2);
    assign w_oor   = |w_hi;
    assign o_fault = w_oor | ~be_legal(i_be, i_a[1:0]);

endmodule

// File: rtl/mem_be_ctrl.sv
// Single-port CPU memory with byte enables plus an always-on video read port.
// Build option: define MEM_CLEAR_EN to zero the data region after reset.
module mem_be_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned WORDS     = 256,
    parameter int unsigned DATA_BASE = 128
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        rvalid,
    output logic        err,
    output logic        ready,
    input  logic [31:0] va,
    output logic [31:0] vd
);

    localparam int unsigned ADDR_W = $clog2(WORDS);

    if (WORDS < 16 || WORDS > 4096 || (WORDS & (WORDS - 1)) != 0 || DATA_BASE >= WORDS) begin : g_param_err
        $error("mem_be_ctrl: illegal WORDS/DATA_BASE combination");
    end

    logic [WORD_W-1:0] r_mem [WORDS];
    logic [WORD_W-1:0] r_rd;
    logic [WORD_W-1:0] r_vd;
    logic              r_rvalid;
    logic              r_err;

    logic [ADDR_W-1:0] w_cpu_idx;
    logic [ADDR_W-1:0] w_va_idx;
    logic [31:0]       w_va_hi;
    logic              w_va_oor;
    logic              w_fault;
    logic              w_ready;
    logic              w_accept;
    logic              w_cpu_we;

    assign w_cpu_idx = a[ADDR_W+1:2];
    assign w_va_idx  = va[ADDR_W+1:2];
    assign w_va_hi   = va >> (ADDR_W + 2);
    assign w_va_oor  = |w_va_hi;

    mem_be_chk #(.ADDR_W(ADDR_W)) u_cpu_chk (
        .i_a     (a),
        .i_be    (be),
        .o_fault (w_fault)
    );

    assign w_accept = req & w_ready;
    // reset_n gates the write so memory is left untouched while reset is held.
    assign w_cpu_we = w_accept & we & ~w_fault & reset_n;

`ifdef MEM_CLEAR_EN
    state_t            r_state;
    logic [ADDR_W-1:0] r_sweep_idx;
    logic              r_ready;
    logic              w_sweep_we;

    // Sweep FSM: clear DATA_BASE..WORDS-1, then accept CPU traffic forever.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= SWEEP;
            r_sweep_idx <= ADDR_W'(DATA_BASE);
            r_ready     <= 1'b0;
        end else if (r_state == SWEEP) begin
            if (r_sweep_idx == ADDR_W'(WORDS - 1)) begin
                r_state <= IDLE;
                r_ready <= 1'b1;
            end else begin
                r_sweep_idx <= r_sweep_idx + 1'b1;
            end
        end
    end

    assign w_sweep_we = (r_state == SWEEP) & reset_n;
    assign w_ready    = r_ready;
`else
    assign w_ready = 1'b1;
`endif

    assign ready = w_ready;

    // Storage: sweep clear or byte-masked CPU write, never both in one cycle.
    always_ff @(posedge clk) begin
`ifdef MEM_CLEAR_EN
        if (w_sweep_we) begin
            r_mem[r_sweep_idx] <= '0;
        end else
`endif
        if (w_cpu_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    r_mem[w_cpu_idx][8*i +: 8] <= wd[8*i +: 8];
                end
            end
        end
    end

    // CPU response: read data, valid pulse and fault pulse one cycle after acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd     <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= w_accept & ~we;
            r_err    <= w_accept & w_fault;
            if (w_accept && !we) begin
                r_rd <= w_fault ? '0 : r_mem[w_cpu_idx];
            end
        end
    end

    // Video read: sampled every cycle, old data wins over a same-cycle write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vd <= '0;
        end else begin
            r_vd <= w_va_oor ? '0 : r_mem[w_va_idx];
        end
    end

    assign rd     = r_rd;
    assign rvalid = r_rvalid;
    assign err    = r_err;
    assign vd     = r_vd;

endmodule

// File: tb/tb_mem_be_ctrl.sv
// Directed bench for mem_be_ctrl (WORDS=256, DATA_BASE=128).
module tb_mem_be_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        rvalid;
    logic        err;
    logic        ready;
    logic [31:0] va;
    logic [31:0] vd;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    mem_be_ctrl #(.WORDS(256), .DATA_BASE(128)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .we      (we),
        .be      (be),
        .a       (a),
        .wd      (wd),
        .rd      (rd),
        .rvalid  (rvalid),
        .err     (err),
        .ready   (ready),
        .va      (va),
        .vd      (vd)
    );

    // Called at a negedge; returns at the next negedge with the response visible.
    task automatic cpu_op(input logic w, input logic [3:0] b, input logic [31:0] addr,
                          input logic [31:0] data);
        req = 1'b1; we = w; be = b; a = addr; wd = data;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int n;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_total++; if (rd !== 32'h0) $display("FAIL rst_rd: got %h expected %h", rd, 32'h0); else n_pass++;
        n_total++; if (vd !== 32'h0) $display("FAIL rst_vd: got %h expected %h", vd, 32'h0); else n_pass++;
        n_total++; if (rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b expected 0", rvalid); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL rst_err: got %b expected 0", err); else n_pass++;
        reset_n = 1'b1;
`ifdef MEM_CLEAR_EN
        n_total++; if (ready !== 1'b0) $display("FAIL rst_ready_low: got %b expected 0", ready); else n_pass++;
        n = 0;
        while (ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        n_total++; if (n != 128) $display("FAIL sweep_len: got %0d expected %0d", n, 128); else n_pass++;
`else
        #1;
        n_total++; if (ready !== 1'b1) $display("FAIL rst_ready_first: got %b expected 1", ready); else n_pass++;
        @(negedge clk);
`endif
    endtask

`ifdef MEM_CLEAR_EN
    task automatic test_sweep_clear();
        cpu_op(1'b0, 4'hF, 32'h200, 32'h0);
        n_total++; if (rd !== 32'h0 || rvalid !== 1'b1) $display("FAIL clr_w128: got %h/%b expected 0/1", rd, rvalid); else n_pass++;
        cpu_op(1'b0, 4'hF, 32'h320, 32'h0);
        n_total++; if (rd !== 32'h0 || err !== 1'b0) $display("FAIL clr_w200: got %h/%b expected 0/0", rd, err); else n_pass++;
        cpu_op(1'b0, 4'hF, 32'h3FC, 32'h0);
        n_total++; if (rd !== 32'h0) $display("FAIL clr_w255: got %h expected 0", rd); else n_pass++;
        req = 1'b0;
    endtask
`endif

    task automatic test_partial_write();
        cpu_op(1'b1, 4'b1111, 32'h200, 32'hAABBCCDD);
        n_total++; if (rvalid !== 1'b0 || err !== 1'b0) $display("FAIL pw_wr_flags: got %b/%b expected 0/0", rvalid, err); else n_pass++;
        // Lanes are not shifted: be=0010 takes wd[15:8], which is 0x00 here.
        cpu_op(1'b1, 4'b0010, 32'h201, 32'h000000EE);
        n_total++; if (err !== 1'b0) $display("FAIL pw_byte_err: got %b expected 0", err); else n_pass++;
        cpu_op(1'b0, 4'b1111, 32'h200, 32'h0);
        n_total++; if (rd !== 32'hAABB00DD) $display("FAIL pw_rd_lane: got %h expected %h", rd, 32'hAABB00DD); else n_pass++;
        n_total++; if (rvalid !== 1'b1) $display("FAIL pw_rvalid: got %b expected 1", rvalid); else n_pass++;
        cpu_op(1'b1, 4'b0010, 32'h201, 32'h0000EE00);
        n_total++; if (rvalid !== 1'b0) $display("FAIL pw_rvalid_pulse: got %b expected 0", rvalid); else n_pass++;
        cpu_op(1'b0, 4'b1111, 32'h200, 32'h0);
        n_total++; if (rd !== 32'hAABBEEDD) $display("FAIL pw_rd_merge: got %h expected %h", rd, 32'hAABBEEDD); else n_pass++;
        cpu_op(1'b1, 4'b1100, 32'h202, 32'h99990000);
        cpu_op(1'b0, 4'b1111, 32'h200, 32'h0);
        n_total++; if (rd !== 32'h9999EEDD) $display("FAIL pw_rd_half: got %h expected %h", rd, 32'h9999EEDD); else n_pass++;
        req = 1'b0;
        @(negedge clk);
        n_total++; if (rvalid !== 1'b0 || rd !== 32'h9999EEDD) $display("FAIL pw_rd_hold: got %h/%b expected %h/0", rd, rvalid, 32'h9999EEDD); else n_pass++;
    endtask

    task automatic test_back_to_back();
        cpu_op(1'b1, 4'hF, 32'h208, 32'h5A5A5A5A);
        cpu_op(1'b0, 4'hF, 32'h208, 32'h0);
        n_total++; if (rd !== 32'h5A5A5A5A || rvalid !== 1'b1) $display("FAIL b2b_full: got %h/%b expected %h/1", rd, rvalid, 32'h5A5A5A5A); else n_pass++;
        cpu_op(1'b1, 4'b0001, 32'h208, 32'h000000C3);
        cpu_op(1'b0, 4'hF, 32'h208, 32'h0);
        n_total++; if (rd !== 32'h5A5A5AC3) $display("FAIL b2b_byte: got %h expected %h", rd, 32'h5A5A5AC3); else n_pass++;
        req = 1'b0;
    endtask

    task automatic test_fault();
        @(negedge clk);
        cpu_op(1'b1, 4'hF, 32'h202, 32'h01010101);
        n_total++; if (err !== 1'b1 || rvalid !== 1'b0) $display("FAIL flt_misalign: got err=%b rvalid=%b expected 1/0", err, rvalid); else n_pass++;
        cpu_op(1'b0, 4'hF, 32'h200, 32'h0);
        n_total++; if (err !== 1'b0 || rd !== 32'h9999EEDD) $display("FAIL flt_unchanged: got %h err=%b expected %h/0", rd, err, 32'h9999EEDD); else n_pass++;
        cpu_op(1'b0, 4'hF, 32'h400, 32'h0);
        n_total++; if (err !== 1'b1 || rvalid !== 1'b1 || rd !== 32'h0) $display("FAIL flt_oor_rd: got %h err=%b rvalid=%b expected 0/1/1", rd, err, rvalid); else n_pass++;
        cpu_op(1'b1, 4'b0000, 32'h200, 32'hFFFFFFFF);
        n_total++; if (err !== 1'b1) $display("FAIL flt_be0: got %b expected 1", err); else n_pass++;
        cpu_op(1'b1, 4'b0110, 32'h200, 32'hFFFFFFFF);
        n_total++; if (err !== 1'b1) $display("FAIL flt_be0110: got %b expected 1", err); else n_pass++;
        cpu_op(1'b1, 4'b1100, 32'h200, 32'hFFFFFFFF);
        n_total++; if (err !== 1'b1) $display("FAIL flt_halfhi_a0: got %b expected 1", err); else n_pass++;
        cpu_op(1'b1, 4'b0100, 32'h201, 32'hFFFFFFFF);
        n_total++; if (err !== 1'b1) $display("FAIL flt_onehot: got %b expected 1", err); else n_pass++;
        cpu_op(1'b1, 4'hF, 32'h80000200, 32'hFFFFFFFF);
        n_total++; if (err !== 1'b1) $display("FAIL flt_hi_addr: got %b expected 1", err); else n_pass++;
        cpu_op(1'b0, 4'hF, 32'h200, 32'h0);
        n_total++; if (rd !== 32'h9999EEDD || err !== 1'b0) $display("FAIL flt_final: got %h err=%b expected %h/0", rd, err, 32'h9999EEDD); else n_pass++;
        req = 1'b0;
        @(negedge clk);
        n_total++; if (err !== 1'b0) $display("FAIL flt_pulse: got %b expected 0", err); else n_pass++;
    endtask

    task automatic test_video();
        cpu_op(1'b1, 4'hF, 32'h300, 32'hCAFEF00D);
        va = 32'h300;
        cpu_op(1'b1, 4'hF, 32'h300, 32'h12345678);
        n_total++; if (vd !== 32'hCAFEF00D) $display("FAIL vid_rbw: got %h expected %h", vd, 32'hCAFEF00D); else n_pass++;
        req = 1'b0;
        @(negedge clk);
        n_total++; if (vd !== 32'h12345678) $display("FAIL vid_new: got %h expected %h", vd, 32'h12345678); else n_pass++;
        va = 32'h303;
        @(negedge clk);
        n_total++; if (vd !== 32'h12345678) $display("FAIL vid_lowbits: got %h expected %h", vd, 32'h12345678); else n_pass++;
        va = 32'h500;
        @(negedge clk);
        n_total++; if (vd !== 32'h0) $display("FAIL vid_oor: got %h expected 0", vd); else n_pass++;
        va = 32'h200;
        @(negedge clk);
        n_total++; if (vd !== 32'h9999EEDD) $display("FAIL vid_w128: got %h expected %h", vd, 32'h9999EEDD); else n_pass++;
    endtask

`ifdef MEM_CLEAR_EN
    task automatic test_reset_mid();
        int n;
        int bad;
        cpu_op(1'b1, 4'hF, 32'h0, 32'h0BADBEEF);
        cpu_op(1'b0, 4'hF, 32'h0, 32'h0);
        n_total++; if (rd !== 32'h0BADBEEF) $display("FAIL mid_prog_rd: got %h expected %h", rd, 32'h0BADBEEF); else n_pass++;
        req = 1'b0;
        va = 32'h0;
        @(negedge clk);
        n_total++; if (vd !== 32'h0BADBEEF) $display("FAIL mid_prog_vd: got %h expected %h", vd, 32'h0BADBEEF); else n_pass++;
        reset_n = 1'b0;
        #1;
        n_total++; if (rd !== 32'h0 || vd !== 32'h0) $display("FAIL mid_async_zero: got rd=%h vd=%h expected 0/0", rd, vd); else n_pass++;
        @(negedge clk);
        req = 1'b1; we = 1'b1; be = 4'hF; a = 32'h0; wd = 32'hDEADDEAD;
        reset_n = 1'b1;
        bad = 0;
        repeat (72) begin
            @(negedge clk);
            if (rvalid !== 1'b0 || err !== 1'b0 || ready !== 1'b0) bad++;
        end
        n_total++; if (bad != 0) $display("FAIL nrdy_ignored: got %0d bad cycles expected 0", bad); else n_pass++;
        n_total++; if (vd !== 32'h0BADBEEF) $display("FAIL mid_vd_sweep: got %h expected %h", vd, 32'h0BADBEEF); else n_pass++;
        #2;
        reset_n = 1'b0;
        #1;
        n_total++; if (vd !== 32'h0 || rvalid !== 1'b0 || err !== 1'b0) $display("FAIL mid200_zero: got vd=%h rvalid=%b err=%b expected 0", vd, rvalid, err); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        req = 1'b0;
        n_total++; if (n != 128) $display("FAIL mid_restart_len: got %0d expected %0d", n, 128); else n_pass++;
        cpu_op(1'b0, 4'hF, 32'h0, 32'h0);
        n_total++; if (rd !== 32'h0BADBEEF) $display("FAIL mid_prog_kept: got %h expected %h", rd, 32'h0BADBEEF); else n_pass++;
        cpu_op(1'b0, 4'hF, 32'h320, 32'h0);
        n_total++; if (rd !== 32'h0) $display("FAIL mid_w200_clr: got %h expected 0", rd); else n_pass++;
        req = 1'b0;
    endtask
`else
    task automatic test_reset_mid();
        cpu_op(1'b1, 4'hF, 32'h20C, 32'h77778888);
        cpu_op(1'b0, 4'hF, 32'h20C, 32'h0);
        n_total++; if (rd !== 32'h77778888) $display("FAIL mid_rd: got %h expected %h", rd, 32'h77778888); else n_pass++;
        req = 1'b0;
        va = 32'h20C;
        @(negedge clk);
        n_total++; if (vd !== 32'h77778888) $display("FAIL mid_vd: got %h expected %h", vd, 32'h77778888); else n_pass++;
        #2;
        reset_n = 1'b0;
        #1;
        n_total++; if (rd !== 32'h0 || vd !== 32'h0 || rvalid !== 1'b0) $display("FAIL mid_async_zero: got rd=%h vd=%h rvalid=%b expected 0", rd, vd, rvalid); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_total++; if (ready !== 1'b1) $display("FAIL mid_ready: got %b expected 1", ready); else n_pass++;
        @(negedge clk);
        cpu_op(1'b0, 4'hF, 32'h20C, 32'h0);
        n_total++; if (rd !== 32'h77778888) $display("FAIL mid_mem_kept: got %h expected %h", rd, 32'h77778888); else n_pass++;
        req = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        req = 1'b0; we = 1'b0; be = 4'h0; a = 32'h0; wd = 32'h0; va = 32'h0;
        @(negedge clk);
        test_reset();
`ifdef MEM_CLEAR_EN
        test_sweep_clear();
`endif
        test_partial_write();
        test_back_to_back();
        test_fault();
        test_video();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
